// File: rtl/dcs_pkg.sv
// Shared types and width helpers for the DCSformer gen-2 Gram engine.
package dcs_pkg;

  typedef enum logic [2:0] {
    LOAD_I = 3'd0,
    GRAM   = 3'd1,
    AVG    = 3'd2,
    THR    = 3'd3,
    LOAD_W = 3'd4,
    OUT    = 3'd5
  } dcs_state_e;

  localparam logic MODE_THRESH = 1'b0;
  localparam logic MODE_BYPASS = 1'b1;

  // One Gram entry: D products of two DW-bit values.
  function automatic int gram_w(int dw, int d);
    return 2 * dw + $clog2(d);
  endfunction

  // One output word: N products of a Gram entry and a DW-bit weight.
  function automatic int out_w(int dw, int d, int n);
    return gram_w(dw, d) + dw + $clog2(n);
  endfunction

endpackage

// File: rtl/dcs_mac_lane.sv
// One lane: registered multiplier feeding an accumulator that can restart a sum.
module dcs_mac_lane #(
  parameter int AW = 20,
  parameter int BW = 8,
  parameter int SW = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mul_en_i,
  input  logic             acc_en_i,
  input  logic             acc_clr_i,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_i,
  output logic [AW+BW-1:0] prod_o,
  output logic [SW-1:0]    acc_o
);

  logic [AW+BW-1:0] prod_q;
  logic [SW-1:0]    acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (mul_en_i) prod_q <= {{BW{1'b0}}, a_i} * {{AW{1'b0}}, b_i};
      // acc_clr_i starts a new sum with the current product instead of adding to it
      if (acc_en_i) acc_q <= (acc_clr_i ? '0 : acc_q) + prod_q[SW-1:0];
    end
  end

  assign prod_o = prod_q;
  assign acc_o  = acc_q;

endmodule

// File: rtl/dcs_gram_engine.sv
// Gram-matrix engine: G = I*I^T, optional below-row-average zeroing, then OUT = G'*W.
module dcs_gram_engine
  import dcs_pkg::*;
#(
  parameter int N  = 8,
  parameter int D  = 16,
  parameter int M  = 1,
  parameter int DW = 8,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] w_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic          busy
);

  localparam int GW   = gram_w(DW, D);
  localparam int PW   = GW + DW;
  localparam int RW   = $clog2(N);
  localparam int SUMW = GW + RW;
  localparam int CMAX = (D > M) ? D : M;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(N - 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);
  localparam logic [CW-1:0] M_LAST = CW'(M - 1);
  localparam logic [15:0]   ND     = 16'(N * D);
  localparam logic [15:0]   ND_END = 16'(N * D + 1);
  localparam logic [15:0]   NN     = 16'(N);

  if (OW < out_w(DW, D, N)) begin : g_bad_ow
    $error("dcs_gram_engine: OW too narrow for DW/D/N");
  end

  dcs_state_e state_q, state_d;
  logic            mode_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [15:0]     cnt_q;
  logic            wdrain_q;
  logic [DW-1:0]   imem_q [N][D];
  logic [GW-1:0]   g_q    [N][N];
  logic [SUMW-1:0] rsum_q [N];
  logic [GW-1:0]   avg_q  [N];
  logic [OW-1:0]   out_q  [N][M];

  logic          gv_p1_q, gfirst_p1_q, glast_p1_q, gv_p2_q, glast_p2_q, wv_p1_q;
  logic [RW-1:0] grow_p1_q, grow_p2_q;
  logic [CW-1:0] wm_p1_q;

  logic          i_fire, w_fire, o_fire, g_issue, lane_mul_en;
  logic [RW-1:0] cnt_row;
  logic [DW-1:0] icol [N];
  logic [DW-1:0] irow;
  logic [GW-1:0] lane_a    [N];
  logic [DW-1:0] lane_b    [N];
  logic [PW-1:0] lane_prod [N];
  logic [GW-1:0] lane_acc  [N];

  assign i_ready     = (state_q == LOAD_I);
  assign w_ready     = (state_q == LOAD_W) && !wdrain_q;
  assign o_valid     = (state_q == OUT);
  assign busy        = (state_q != LOAD_I);
  assign i_fire      = i_valid && i_ready;
  assign w_fire      = w_valid && w_ready;
  assign o_fire      = o_valid && o_ready;
  assign g_issue     = (state_q == GRAM) && (cnt_q < ND);
  assign lane_mul_en = g_issue || w_fire;
  assign cnt_row     = cnt_q[RW-1:0];

  // GRAM feeds lane l with I[r][k]*I[l][k]; LOAD_W feeds it G[l][j]*W[j][m].
  always_comb begin
    for (int l = 0; l < N; l++) begin
      icol[l] = '0;
      for (int k = 0; k < D; k++)
        if (col_q == CW'(k)) icol[l] = imem_q[l][k];
    end
    irow = icol[row_q];
    for (int l = 0; l < N; l++) begin
      if (state_q == LOAD_W) begin
        lane_a[l] = g_q[l][row_q];
        lane_b[l] = w_data;
      end else begin
        lane_a[l] = GW'(irow);
        lane_b[l] = icol[l];
      end
    end
  end

  for (genvar l = 0; l < N; l++) begin : g_lane
    dcs_mac_lane #(.AW(GW), .BW(DW), .SW(GW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .mul_en_i  (lane_mul_en),
      .acc_en_i  (gv_p1_q),
      .acc_clr_i (gfirst_p1_q),
      .a_i       (lane_a[l]),
      .b_i       (lane_b[l]),
      .prod_o    (lane_prod[l]),
      .acc_o     (lane_acc[l])
    );
  end

  always_comb begin
    o_data = '0;
    if (state_q == OUT)
      for (int i = 0; i < N; i++)
        for (int m = 0; m < M; m++)
          if (row_q == RW'(i) && col_q == CW'(m)) o_data = out_q[i][m];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_I: if (i_fire && row_q == R_LAST && col_q == D_LAST) state_d = GRAM;
      GRAM:   if (cnt_q == ND_END) state_d = AVG;
      AVG:    if (cnt_q == NN) state_d = THR;
      THR:    if (cnt_q == NN - 16'd1) state_d = LOAD_W;
      LOAD_W: if (wdrain_q && cnt_q == 16'd1) state_d = OUT;
      OUT:    if (o_fire && row_q == R_LAST && col_q == M_LAST) state_d = LOAD_I;
      default: state_d = LOAD_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD_I;
      mode_q      <= MODE_THRESH;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      wdrain_q    <= 1'b0;
      gv_p1_q     <= 1'b0;
      gfirst_p1_q <= 1'b0;
      glast_p1_q  <= 1'b0;
      grow_p1_q   <= '0;
      gv_p2_q     <= 1'b0;
      glast_p2_q  <= 1'b0;
      grow_p2_q   <= '0;
      wv_p1_q     <= 1'b0;
      wm_p1_q     <= '0;
      for (int r = 0; r < N; r++) begin
        rsum_q[r] <= '0;
        avg_q[r]  <= '0;
        for (int k = 0; k < D; k++) imem_q[r][k] <= '0;
        for (int j = 0; j < N; j++) g_q[r][j] <= '0;
        for (int m = 0; m < M; m++) out_q[r][m] <= '0;
      end
    end else begin
      state_q <= state_d;
      // p1: product registered in the lanes; p2: lane accumulator holds the row sum
      gv_p1_q     <= g_issue;
      gfirst_p1_q <= (col_q == '0);
      glast_p1_q  <= (col_q == D_LAST);
      grow_p1_q   <= row_q;
      gv_p2_q     <= gv_p1_q;
      glast_p2_q  <= glast_p1_q;
      grow_p2_q   <= grow_p1_q;
      wv_p1_q     <= w_fire;
      wm_p1_q     <= col_q;
      if (gv_p2_q && glast_p2_q)
        for (int l = 0; l < N; l++) g_q[grow_p2_q][l] <= lane_acc[l];
      if (wv_p1_q)
        for (int i = 0; i < N; i++)
          for (int m = 0; m < M; m++)
            if (wm_p1_q == CW'(m)) out_q[i][m] <= out_q[i][m] + OW'(lane_prod[i]);

      case (state_q)
        LOAD_I: if (i_fire) begin
          for (int k = 0; k < D; k++)
            if (col_q == CW'(k)) imem_q[row_q][k] <= i_data;
          col_q <= (col_q == D_LAST) ? '0 : col_q + 1'b1;
          if (col_q == D_LAST) row_q <= row_q + 1'b1;
          if (state_d == GRAM) mode_q <= mode;
        end
        GRAM: begin
          cnt_q <= (state_d == AVG) ? '0 : cnt_q + 16'd1;
          if (g_issue) begin
            col_q <= (col_q == D_LAST) ? '0 : col_q + 1'b1;
            if (col_q == D_LAST) row_q <= row_q + 1'b1;
          end
        end
        AVG: begin
          cnt_q <= (state_d == THR) ? '0 : cnt_q + 16'd1;
          for (int r = 0; r < N; r++)
            if (cnt_q < NN) rsum_q[r] <= rsum_q[r] + SUMW'(g_q[r][cnt_row]);
            else            avg_q[r]  <= GW'(rsum_q[r] >> RW);
        end
        THR: begin
          cnt_q <= (state_d == LOAD_W) ? '0 : cnt_q + 16'd1;
          if (mode_q == MODE_THRESH)
            for (int j = 0; j < N; j++)
              if (g_q[cnt_row][j] < avg_q[cnt_row]) g_q[cnt_row][j] <= '0;
        end
        LOAD_W: begin
          if (w_fire) begin
            col_q <= (col_q == M_LAST) ? '0 : col_q + 1'b1;
            if (col_q == M_LAST) row_q <= row_q + 1'b1;
            if (row_q == R_LAST && col_q == M_LAST) begin
              wdrain_q <= 1'b1;
              cnt_q    <= '0;
            end
          end
          if (wdrain_q) cnt_q <= cnt_q + 16'd1;
          if (state_d == OUT) begin
            wdrain_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        OUT: if (o_fire) begin
          col_q <= (col_q == M_LAST) ? '0 : col_q + 1'b1;
          if (col_q == M_LAST) row_q <= row_q + 1'b1;
          if (state_d == LOAD_I)
            for (int r = 0; r < N; r++) begin
              rsum_q[r] <= '0;
              avg_q[r]  <= '0;
              for (int j = 0; j < N; j++) g_q[r][j] <= '0;
              for (int m = 0; m < M; m++) out_q[r][m] <= '0;
            end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcs_gram_engine.sv
// Directed bench for dcs_gram_engine: default 8x16x1 instance plus a 4x8x2 instance.
module tb_dcs_gram_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mode;
  logic iv_a, wv_a, ordy_a, ir_a, wr_a, ov_a, busy_a;
  logic [7:0] id_a, wd_a;
  logic [31:0] od_a;
  logic iv_b, wv_b, ordy_b, ir_b, wr_b, ov_b, busy_b;
  logic [7:0] id_b, wd_b;
  logic [31:0] od_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [16];

  dcs_gram_engine u_a (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .i_valid(iv_a), .i_ready(ir_a), .i_data(id_a),
    .w_valid(wv_a), .w_ready(wr_a), .w_data(wd_a),
    .o_valid(ov_a), .o_ready(ordy_a), .o_data(od_a), .busy(busy_a)
  );

  dcs_gram_engine #(.N(4), .D(8), .M(2)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .i_valid(iv_b), .i_ready(ir_b), .i_data(id_b),
    .w_valid(wv_b), .w_ready(wr_b), .w_data(wd_b),
    .o_valid(ov_b), .o_ready(ordy_b), .o_data(od_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic send_i(input bit b, input logic [7:0] v);
    int n = 0;
    if (b) begin iv_b = 1'b1; id_b = v; end else begin iv_a = 1'b1; id_a = v; end
    while ((b ? ir_b : ir_a) !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("i_ready_timeout", 64'(n), 64'd0);
    @(posedge clk);
    @(negedge clk);
    if (b) iv_b = 1'b0; else iv_a = 1'b0;
  endtask

  task automatic send_w(input bit b, input logic [7:0] v);
    int n = 0;
    if (b) begin wv_b = 1'b1; wd_b = v; end else begin wv_a = 1'b1; wd_a = v; end
    while ((b ? wr_b : wr_a) !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("w_ready_timeout", 64'(n), 64'd0);
    @(posedge clk);
    @(negedge clk);
    if (b) wv_b = 1'b0; else wv_a = 1'b0;
  endtask

  // kind 0: all ones; kind 1: I[r][0]=r+1 else 0; kind 2: all 255
  task automatic load_i(input bit b, input int kind, input int rows, input int cols);
    logic [7:0] v;
    for (int r = 0; r < rows; r++)
      for (int k = 0; k < cols; k++) begin
        v = (kind == 0) ? 8'd1 : (kind == 1) ? ((k == 0) ? 8'(r + 1) : 8'd0) : 8'd255;
        send_i(b, v);
      end
  endtask

  // Returns the cycle offset (1 = first cycle after the last I handshake) at which w_ready rises.
  task automatic wait_wready(input bit b, input bit pulse_w, output int n);
    n = 1;
    while ((b ? wr_b : wr_a) !== 1'b1 && n < 400) begin
      if (pulse_w) begin wv_a = (n >= 3 && n < 40); wd_a = 8'hFF; end
      @(negedge clk);
      n++;
    end
    if (pulse_w) wv_a = 1'b0;
    if (n >= 400) chk("w_ready_wait_timeout", 64'(n), 64'd0);
  endtask

  task automatic load_w(input bit b, input logic [7:0] v, input int cnt, output int lat);
    for (int e = 0; e < cnt; e++) send_w(b, v);
    lat = 1;
    while ((b ? ov_b : ov_a) !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic recv(input bit b, input int cnt, input int hold_at, input string tag);
    int n;
    logic [31:0] held;
    for (int e = 0; e < cnt; e++) begin
      n = 0;
      while ((b ? ov_b : ov_a) !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk({tag, "_ovalid_timeout"}, 64'(n), 64'd0);
      if (e == hold_at) begin
        held = b ? od_b : od_a;
        if (b) ordy_b = 1'b0; else ordy_a = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk({tag, "_hold_data"}, 64'(b ? od_b : od_a), 64'(held));
          chk({tag, "_hold_valid"}, 64'(b ? ov_b : ov_a), 64'd1);
        end
        if (b) ordy_b = 1'b1; else ordy_a = 1'b1;
      end
      chk($sformatf("%s_word%0d", tag, e), 64'(b ? od_b : od_a), 64'(exp_q[e]));
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_idle_busy"}, 64'(b ? busy_b : busy_a), 64'd0);
    chk({tag, "_idle_iready"}, 64'(b ? ir_b : ir_a), 64'd1);
    chk({tag, "_idle_ovalid"}, 64'(b ? ov_b : ov_a), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;
    int thr_exp [8] = '{30, 52, 78, 104, 130, 156, 182, 208};
    int byp_exp [8] = '{36, 72, 108, 144, 180, 216, 252, 288};
    rst_n = 1'b0; mode = 1'b0;
    iv_a = 1'b0; wv_a = 1'b0; ordy_a = 1'b1; id_a = '0; wd_a = '0;
    iv_b = 1'b0; wv_b = 1'b0; ordy_b = 1'b1; id_b = '0; wd_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iready", 64'(ir_a), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_wready", 64'(wr_a), 64'd0);
    chk("rst_ovalid", 64'(ov_a), 64'd0);
    chk("rst_odata", 64'(od_a), 64'd0);
    chk("rst_b_iready", 64'(ir_b), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: all ones, threshold mode
    mode = 1'b0;
    load_i(1'b0, 0, 8, 16);
    chk("gram_busy", 64'(busy_a), 64'd1);
    wait_wready(1'b0, 1'b0, n);
    chk("w_ready_latency", 64'(n), 64'd148);
    load_w(1'b0, 8'd1, 8, lat);
    chk("o_valid_latency", 64'(lat), 64'd3);
    for (int e = 0; e < 8; e++) exp_q[e] = 32'd128;
    recv(1'b0, 8, -1, "ones");

    // Scenario 2a: ramp in column 0, threshold; stray w_valid in GRAM, stray i_valid in LOAD_W
    mode = 1'b0;
    load_i(1'b0, 1, 8, 16);
    mode = 1'b1;
    wait_wready(1'b0, 1'b1, n);
    iv_a = 1'b1; id_a = 8'hAA;
    load_w(1'b0, 8'd1, 8, lat);
    iv_a = 1'b0;
    for (int e = 0; e < 8; e++) exp_q[e] = 32'(thr_exp[e]);
    recv(1'b0, 8, -1, "ramp_thr");

    // Scenario 2b: same ramp in bypass, with o_ready held low at the third word
    mode = 1'b1;
    load_i(1'b0, 1, 8, 16);
    mode = 1'b0;
    wait_wready(1'b0, 1'b0, n);
    load_w(1'b0, 8'd1, 8, lat);
    for (int e = 0; e < 8; e++) exp_q[e] = 32'(byp_exp[e]);
    recv(1'b0, 8, 2, "ramp_byp");

    // Scenario 3: full-scale values, bypass
    mode = 1'b1;
    load_i(1'b0, 2, 8, 16);
    wait_wready(1'b0, 1'b0, n);
    load_w(1'b0, 8'd255, 8, lat);
    for (int e = 0; e < 8; e++) exp_q[e] = 32'd2122416000;
    recv(1'b0, 8, -1, "maxval");

    // Scenario 5: reset in the middle of GRAM, then a clean all-ones batch
    mode = 1'b0;
    load_i(1'b0, 0, 8, 16);
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_iready", 64'(ir_a), 64'd1);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_ovalid", 64'(ov_a), 64'd0);
    chk("midrst_wready", 64'(wr_a), 64'd0);
    load_i(1'b0, 0, 8, 16);
    wait_wready(1'b0, 1'b0, n);
    chk("post_rst_w_ready_latency", 64'(n), 64'd148);
    load_w(1'b0, 8'd1, 8, lat);
    for (int e = 0; e < 8; e++) exp_q[e] = 32'd128;
    recv(1'b0, 8, -1, "post_rst");

    // Small instance: N=4, D=8, M=2, I all 1, W all 2
    mode = 1'b0;
    load_i(1'b1, 0, 4, 8);
    wait_wready(1'b1, 1'b0, n);
    chk("b_w_ready_latency", 64'(n), 64'd44);
    load_w(1'b1, 8'd2, 8, lat);
    chk("b_o_valid_latency", 64'(lat), 64'd3);
    for (int e = 0; e < 8; e++) exp_q[e] = 32'd64;
    recv(1'b1, 8, -1, "small");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
